// File: rtl/viewport_mapper.sv
`timescale 1ns/1ps
`default_nettype none
// viewport_mapper: 3-stage pipeline mapping fp32 NDC vertices to fixed-point screen x/y and a depth code.
// Build option: define VIEWPORT_CULL_EN to drop clipped vertices at the output stage instead of emitting them.
module viewport_mapper #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int FRAC_BITS  = 4,
  parameter int DEPTH_BITS = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [3:0][31:0]      vertex_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [15:0]           x_out,
  output logic [15:0]           y_out,
  output logic [DEPTH_BITS-1:0] z_out,
  output logic                  clipped_out
);

  // Internal NDC format: signed, 20 fraction bits, wide enough to hold the +/-2.0 saturation value.
  localparam int IF_BITS = 20;
  localparam int FW      = 24;
  localparam int PW      = 52;
  localparam int SH_XY   = IF_BITS + 1 - FRAC_BITS;
  localparam int SH_Z    = IF_BITS + 1;

  localparam logic [FW-1:0]        SAT_F   = FW'(1 << (IF_BITS + 1));
  localparam logic signed [PW-1:0] ONE_P   = PW'(1 << IF_BITS);
  localparam logic signed [PW-1:0] W_P     = PW'(SCREEN_W);
  localparam logic signed [PW-1:0] H_P     = PW'(SCREEN_H);
  localparam logic signed [PW-1:0] DMAX_P  = PW'((1 << DEPTH_BITS) - 1);
  localparam logic signed [PW-1:0] HALF_XY = PW'(1 << (SH_XY - 1));
  localparam logic signed [PW-1:0] HALF_Z  = PW'(1 << (SH_Z - 1));
  localparam logic signed [PW-1:0] XMAX_P  = PW'(SCREEN_W << FRAC_BITS);
  localparam logic signed [PW-1:0] YMAX_P  = PW'(SCREEN_H << FRAC_BITS);

  function automatic logic signed [FW-1:0] to_fixed(input logic [31:0] f);
    logic [7:0]    e;
    logic [8:0]    sh;
    logic [FW-1:0] mag;
    e   = f[30:23];
    sh  = 9'd130 - {1'b0, e};
    mag = '0;
    if (e == 8'hFF && f[22:0] != 23'd0) begin
      mag = '0;
    end else if (e >= 8'd128) begin
      mag = SAT_F;
    end else if (e != 8'd0 && sh < 9'd24) begin
      mag = {1'b1, f[22:0]} >> sh[4:0];
    end
    return f[31] ? -$signed(mag) : $signed(mag);
  endfunction

  // Exactly +/-1.0 is in range; anything larger in magnitude, Inf or NaN is clipped.
  function automatic logic out_of_range(input logic [31:0] f);
    return (f[30:23] > 8'd127) || (f[30:23] == 8'd127 && f[22:0] != 23'd0);
  endfunction

  logic                  enable;
  logic                  v1, v2, v3_next;
  logic signed [FW-1:0]  x1, y1, z1;
  logic                  c1, c2;
  logic signed [PW-1:0]  px, py, pz;
  logic signed [PW-1:0]  rx, ry, rz;
  logic [15:0]           x_q, y_q;
  logic [DEPTH_BITS-1:0] z_q;
  logic                  unused_w;

  assign unused_w  = ^vertex_in[3];
  assign enable    = !valid_out || ready_in;
  assign ready_out = enable;

`ifdef VIEWPORT_CULL_EN
  assign v3_next = v2 && !c2;
`else
  assign v3_next = v2;
`endif

  // Round half toward +inf by adding half an LSB before the floor shift, then clamp.
  always_comb begin
    rx = (px + HALF_XY) >>> SH_XY;
    ry = (py + HALF_XY) >>> SH_XY;
    rz = (pz + HALF_Z) >>> SH_Z;

    x_q = 16'd0;
    if (rx[PW-1])          x_q = 16'd0;
    else if (rx > XMAX_P)  x_q = XMAX_P[15:0];
    else                   x_q = rx[15:0];

    y_q = 16'd0;
    if (ry[PW-1])          y_q = 16'd0;
    else if (ry > YMAX_P)  y_q = YMAX_P[15:0];
    else                   y_q = ry[15:0];

    z_q = '0;
    if (rz[PW-1])          z_q = '0;
    else if (rz > DMAX_P)  z_q = DMAX_P[DEPTH_BITS-1:0];
    else                   z_q = rz[DEPTH_BITS-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      valid_out   <= 1'b0;
      x1          <= '0;
      y1          <= '0;
      z1          <= '0;
      c1          <= 1'b0;
      px          <= '0;
      py          <= '0;
      pz          <= '0;
      c2          <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      z_out       <= '0;
      clipped_out <= 1'b0;
    end else if (enable) begin
      v1 <= valid_in;
      if (valid_in) begin
        x1 <= to_fixed(vertex_in[0]);
        y1 <= to_fixed(vertex_in[1]);
        z1 <= to_fixed(vertex_in[2]);
        c1 <= out_of_range(vertex_in[0]) | out_of_range(vertex_in[1]) |
              out_of_range(vertex_in[2]);
      end

      v2 <= v1;
      if (v1) begin
        px <= (PW'(x1) + ONE_P) * W_P;
        py <= (ONE_P - PW'(y1)) * H_P;
        pz <= (PW'(z1) + ONE_P) * DMAX_P;
        c2 <= c1;
      end

      valid_out <= v3_next;
      if (v2) begin
        x_out       <= x_q;
        y_out       <= y_q;
        z_out       <= z_q;
        clipped_out <= c2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_viewport_mapper.sv
`timescale 1ns/1ps
`default_nettype none
// tb_viewport_mapper: directed + randomized stimulus against a real-arithmetic reference model and scoreboard.
module tb_viewport_mapper;
  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int FRAC_BITS  = 4;
  localparam int DEPTH_BITS = 16;

  typedef struct packed {
    logic [15:0]           x;
    logic [15:0]           y;
    logic [DEPTH_BITS-1:0] z;
    logic                  c;
    logic [31:0]           tag;
  } exp_t;

  typedef struct packed {
    logic [3:0][31:0] vtx;
    exp_t             exp;
    logic             has_exp;
  } item_t;

  logic                  clk_in   = 1'b0;
  logic                  rst_in   = 1'b1;
  logic                  valid_in = 1'b0;
  logic                  ready_in = 1'b0;
  logic [3:0][31:0]      vertex_in = '0;
  logic                  ready_out;
  logic                  valid_out;
  logic [15:0]           x_out;
  logic [15:0]           y_out;
  logic [DEPTH_BITS-1:0] z_out;
  logic                  clipped_out;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned en_cnt   = 0;
  exp_t        sb[$];
  item_t       pend[$];

  viewport_mapper #(
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .FRAC_BITS (FRAC_BITS),
    .DEPTH_BITS(DEPTH_BITS)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .vertex_in  (vertex_in),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .clipped_out(clipped_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: decode fp32 to a real NDC value, apply the viewport equations, round half up, clamp.
  function automatic real ndc(input logic [31:0] b, output logic clip);
    real v;
    int  ex;
    clip = 1'b0;
    if (b[30:23] == 8'hFF) begin
      clip = 1'b1;
      if (b[22:0] != 23'd0) return 0.0;
      return b[31] ? -2.0 : 2.0;
    end
    if (b[30:23] == 8'h00) return 0.0;
    v  = 1.0 + real'(b[22:0]) / 8388608.0;
    ex = int'(b[30:23]) - 127;
    for (int i = 0; i < ex; i++) v = v * 2.0;
    for (int i = 0; i < -ex; i++) v = v / 2.0;
    if (b[31]) v = -v;
    clip = (v > 1.0) || (v < -1.0);
    if (v > 2.0) v = 2.0;
    if (v < -2.0) v = -2.0;
    return v;
  endfunction

  function automatic logic [31:0] quant(input real v, input real hi);
    real r;
    r = $floor(v + 0.5);
    if (r < 0.0) r = 0.0;
    if (r > hi) r = hi;
    return 32'($rtoi(r));
  endfunction

  function automatic exp_t model(input logic [3:0][31:0] v);
    exp_t r;
    real  x, y, z, fs, dm;
    logic cx, cy, cz;
    fs  = real'(1 << FRAC_BITS);
    dm  = real'((1 << DEPTH_BITS) - 1);
    x   = ndc(v[0], cx);
    y   = ndc(v[1], cy);
    z   = ndc(v[2], cz);
    r.x = 16'(quant((x + 1.0) * SCREEN_W / 2.0 * fs, SCREEN_W * fs));
    r.y = 16'(quant((1.0 - y) * SCREEN_H / 2.0 * fs, SCREEN_H * fs));
    r.z = DEPTH_BITS'(quant((z + 1.0) / 2.0 * dm, dm));
    r.c = cx | cy | cz;
    r.tag = 32'd0;
    return r;
  endfunction

  // Exact fp32 encoding of k / 65536 (|k| < 2^18), so every stimulus value is a multiple of 2^-16.
  function automatic logic [31:0] k_to_fp(input int k);
    logic [31:0] mag, b;
    int          p;
    if (k == 0) return 32'd0;
    mag = (k < 0) ? 32'(-k) : 32'(k);
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    b[31]    = (k < 0);
    b[30:23] = 8'(127 + p - 16);
    b[22:0]  = 23'(mag << (23 - p));
    return b;
  endfunction

  function automatic logic [31:0] rand_coord(input logic in_range);
    int          k;
    int unsigned sel;
    sel = in_range ? 32'd1 : $urandom_range(15);
    if (sel == 0) begin
      case ($urandom_range(7))
        0: return 32'h7FC00000;
        1: return 32'h7F800000;
        2: return 32'hFF800000;
        3: return 32'h00000005;
        4: return 32'h80000000;
        5: return 32'h3F800000;
        6: return 32'hBF800000;
        default: return 32'hC0400000;
      endcase
    end
    if (sel < 12) k = int'($urandom_range(131072)) - 65536;
    else          k = int'($urandom_range(327680)) - 163840;
    return k_to_fp(k);
  endfunction

  function automatic item_t rand_item(input logic in_range);
    item_t it;
    it.vtx[0]  = rand_coord(in_range);
    it.vtx[1]  = rand_coord(in_range);
    it.vtx[2]  = rand_coord(in_range);
    it.vtx[3]  = $urandom;
    it.exp     = '0;
    it.has_exp = 1'b0;
    return it;
  endfunction

  function automatic item_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                               input int ex, input int ey, input int ez, input logic ec);
    item_t it;
    it.vtx     = {32'h3F800000, z, y, x};
    it.exp.x   = 16'(ex);
    it.exp.y   = 16'(ey);
    it.exp.z   = DEPTH_BITS'(ez);
    it.exp.c   = ec;
    it.exp.tag = 32'd0;
    it.has_exp = 1'b1;
    return it;
  endfunction

  // One cycle: drive at negedge, then inspect handshakes and outputs that the next posedge will act on.
  task automatic tick(input logic vin, input item_t it, input logic rdy, output logic acc);
    exp_t e;
    @(negedge clk_in);
    valid_in  = vin;
    vertex_in = it.vtx;
    ready_in  = rdy;
    #1;
    if (valid_out) begin
      if (sb.size() == 0) begin
        check("extra_out", 32'(valid_out), 32'd0);
      end else begin
        e = sb[0];
        check("x_out", 32'(x_out), 32'(e.x));
        check("y_out", 32'(y_out), 32'(e.y));
        check("z_out", 32'(z_out), 32'(e.z));
        check("clipped_out", 32'(clipped_out), 32'(e.c));
        if (ready_in) begin
          check("latency", en_cnt - e.tag, 32'd3);
          sb.delete(0);
        end
      end
    end
    acc = valid_in && ready_out;
    if (acc) begin
      e     = it.has_exp ? it.exp : model(it.vtx);
      e.tag = en_cnt;
`ifdef VIEWPORT_CULL_EN
      if (!e.c) sb.push_back(e);
`else
      sb.push_back(e);
`endif
    end
    if (ready_out) en_cnt++;
  endtask

  task automatic run(input int vld_pct, input int rdy_pct, input int budget);
    logic  acc, vin;
    item_t it;
    for (int c = 0; c < budget && pend.size() > 0; c++) begin
      vin = int'($urandom_range(99)) < vld_pct;
      it  = vin ? pend[0] : rand_item(1'b0);
      tick(vin, it, int'($urandom_range(99)) < rdy_pct, acc);
      if (acc) pend.delete(0);
    end
    check("send_done", 32'(pend.size()), 32'd0);
    pend.delete();
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 40 && sb.size() > 0; c++) tick(1'b0, rand_item(1'b0), 1'b1, acc);
    check("drain", 32'(sb.size()), 32'd0);
    for (int c = 0; c < 4; c++) tick(1'b0, rand_item(1'b0), 1'b1, acc);
  endtask

  initial begin
    logic  acc;
    item_t it;

    #1 rst_in = 1'b0;
    #1;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_z_out", 32'(z_out), 32'd0);
    check("rst_clipped", 32'(clipped_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;

    // Corners and centre, back-to-back with ready_in high
    pend.push_back(mk(32'hBF800000, 32'h3F800000, 32'h0, 0, 0, 32768, 1'b0));
    pend.push_back(mk(32'hBF800000, 32'hBF800000, 32'h0, 0, 3840, 32768, 1'b0));
    pend.push_back(mk(32'h3F800000, 32'hBF800000, 32'h0, 5120, 3840, 32768, 1'b0));
    pend.push_back(mk(32'h3F800000, 32'h3F800000, 32'h0, 5120, 0, 32768, 1'b0));
    pend.push_back(mk(32'h00000000, 32'h00000000, 32'h0, 2560, 1920, 32768, 1'b0));
    run(100, 100, 50);
    drain();

    // Half-scale point, depth extremes, overrange and NaN
    pend.push_back(mk(32'h3F000000, 32'h3F000000, 32'h0, 3840, 960, 32768, 1'b0));
    pend.push_back(mk(32'h0, 32'h0, 32'hBF800000, 2560, 1920, 0, 1'b0));
    pend.push_back(mk(32'h0, 32'h0, 32'h3F800000, 2560, 1920, 65535, 1'b0));
    pend.push_back(mk(32'h40000000, 32'h0, 32'h0, 5120, 1920, 32768, 1'b1));
    pend.push_back(mk(32'h0, 32'h7FC00000, 32'h0, 2560, 1920, 32768, 1'b1));
    pend.push_back(mk(32'h3F000000, 32'h3F000000, 32'hBF800000, 3840, 960, 0, 1'b0));
    run(100, 100, 50);
    drain();

    // Downstream stall for 5 cycles while 4 vertices stream in
    for (int i = 0; i < 4; i++) pend.push_back(rand_item(1'b1));
    for (int c = 0; c < 30 && (pend.size() > 0 || c < 5); c++) begin
      it = (pend.size() > 0) ? pend[0] : rand_item(1'b0);
      tick(pend.size() > 0, it, c >= 5, acc);
      if (acc) pend.delete(0);
      if (c == 4) check("stall_ready_out", 32'(ready_out), 32'd0);
    end
    check("stall_sent", 32'(pend.size()), 32'd0);
    pend.delete();
    drain();

    // Asynchronous reset with two vertices in flight
    tick(1'b1, mk(32'h3F000000, 32'h3F000000, 32'h0, 3840, 960, 32768, 1'b0), 1'b1, acc);
    tick(1'b1, mk(32'hBF000000, 32'h3F000000, 32'h0, 1280, 960, 32768, 1'b0), 1'b1, acc);
    tick(1'b0, rand_item(1'b0), 1'b1, acc);
    @(posedge clk_in);
    #2;
    check("pre_rst_valid_out", 32'(valid_out), 32'd1);
    rst_in = 1'b0;
    #1;
    check("midrst_valid_out", 32'(valid_out), 32'd0);
    check("midrst_x_out", 32'(x_out), 32'd0);
    check("midrst_y_out", 32'(y_out), 32'd0);
    check("midrst_z_out", 32'(z_out), 32'd0);
    sb.delete();
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, rand_item(1'b0), 1'b1, acc);
      check("postrst_no_emit", 32'(valid_out), 32'd0);
      if (c == 0) check("postrst_ready_out", 32'(ready_out), 32'd1);
    end

    // Randomized traffic with random bubbles and backpressure
    for (int i = 0; i < 300; i++) pend.push_back(rand_item(1'b0));
    run(75, 70, 4000);
    drain();
    for (int i = 0; i < 150; i++) pend.push_back(rand_item(1'b0));
    run(100, 100, 400);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
